pll_lock_seq: RTL and testbench

PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

---
 rtl/pll_lock_seq.sv | 189 ++++++++++++++++++
 tb/tb_pll_lock_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_seq.sv
// pll_lock_seq: PLL reset / lock-qualification sequencer with staggered
// release of downstream domain resets.
//
// Ports:
//   refclk       - reference clock (only clock)
//   rst          - synchronous active-high reset
//   pll_locked   - asynchronous lock indication from the PLL
//   force_relock - single-cycle request to restart the sequence
//   pll_rst      - reset to the PLL
//   domain_rst   - per-domain active-high resets, bit i for outclk_i
//   ready        - all domains released and PLL locked
//   fail         - lock retries exhausted
//   retry_count  - retries used in the current sequence
module pll_lock_seq #(
  parameter int unsigned NUM_CLOCKS          = 2,
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned STAGGER_CYCLES      = 8,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                                 refclk,
  input  logic                                 rst,
  input  logic                                 pll_locked,
  input  logic                                 force_relock,
  output logic                                 pll_rst,
  output logic [NUM_CLOCKS-1:0]                domain_rst,
  output logic                                 ready,
  output logic                                 fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_count
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned RELEASE_CYCLES = STAGGER_CYCLES * NUM_CLOCKS;
  localparam int unsigned CNT_MAX = max2(max2(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES),
                                         max2(LOCK_STABLE_CYCLES, RELEASE_CYCLES));
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   retry_d;
  logic            sync1_q, locked_s;
  logic            pll_rst_d, ready_d, fail_d;
  logic [NUM_CLOCKS-1:0] domain_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_count;
    pll_rst_d = pll_rst;
    domain_d  = domain_rst;
    ready_d   = 1'b0;
    fail_d    = 1'b0;

    if (force_relock) begin
      state_d   = RESET_PLL;
      cnt_d     = '0;
      retry_d   = '0;
      pll_rst_d = 1'b1;
      domain_d  = '1;
    end else begin
      unique case (state_q)
        RESET_PLL: begin
          pll_rst_d = 1'b1;
          domain_d  = '1;
          if (cnt_q == RST_LAST) begin
            state_d   = WAIT_LOCK;
            cnt_d     = '0;
            pll_rst_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          pll_rst_d = 1'b0;
          domain_d  = '1;
          if (locked_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d     = '0;
            pll_rst_d = 1'b1;
            if (retry_count == RETRY_MAX) begin
              state_d = FAIL;
              fail_d  = 1'b1;
            end else begin
              state_d = RESET_PLL;
              retry_d = retry_count + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STABLE: begin
          pll_rst_d = 1'b0;
          domain_d  = '1;
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE, RUN: begin
          if (!locked_s) begin
            // Lock lost after release: full restart with a fresh retry budget.
            state_d   = RESET_PLL;
            cnt_d     = '0;
            retry_d   = '0;
            pll_rst_d = 1'b1;
            domain_d  = '1;
          end else if (state_q == RUN) begin
            ready_d  = 1'b1;
            domain_d = '0;
          end else begin
            // Bit i clears once STAGGER_CYCLES*(i+1) cycles have elapsed.
            for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
              if (cnt_q == CW'(STAGGER_CYCLES * (i + 1) - 1)) domain_d[i] = 1'b0;
            end
            if (cnt_q == RELEASE_LAST) begin
              state_d = RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        FAIL: begin
          pll_rst_d = 1'b1;
          domain_d  = '1;
          fail_d    = 1'b1;
        end
        default: begin
          state_d   = RESET_PLL;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
          domain_d  = '1;
        end
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      sync1_q     <= 1'b0;
      locked_s    <= 1'b0;
      pll_rst     <= 1'b1;
      domain_rst  <= '1;
      ready       <= 1'b0;
      fail        <= 1'b0;
      retry_count <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync1_q     <= pll_locked;
      locked_s    <= sync1_q;
      pll_rst     <= pll_rst_d;
      domain_rst  <= domain_d;
      ready       <= ready_d;
      fail        <= fail_d;
      retry_count <= retry_d;
    end
  end

endmodule

// File: tb/tb_pll_lock_seq.sv
// tb_pll_lock_seq: directed self-checking bench for pll_lock_seq using
// NUM_CLOCKS=2, RST_PULSE=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, STAGGER=2,
// MAX_RETRIES=2. "Edge N" is the N-th rising edge after rst drops (from 0);
// a value "at edge N" is sampled on the falling edge just before edge N.
module tb_pll_lock_seq;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic [1:0] domain_rst;
  logic       ready;
  logic       fail;
  logic [1:0] retry_count;

  int tests_run = 0;
  int tests_failed = 0;
  int edges = 0;

  pll_lock_seq #(
    .NUM_CLOCKS(2),
    .RST_PULSE_CYCLES(4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES(8),
    .STAGGER_CYCLES(2),
    .MAX_RETRIES(2)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .force_relock(force_relock),
    .pll_rst(pll_rst),
    .domain_rst(domain_rst),
    .ready(ready),
    .fail(fail),
    .retry_count(retry_count)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    edges++;
    @(negedge refclk);
  endtask

  task automatic goto(input int n);
    while (edges < n) tick();
  endtask

  task automatic do_reset(input logic lk);
    rst = 1'b1;
    force_relock = 1'b0;
    pll_locked = lk;
    repeat (3) tick();
    rst = 1'b0;
    edges = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    force_relock = 1'b1;
    pll_locked = 1'b1;
    repeat (3) tick();
    tests_run++; if (pll_rst !== 1'b1) begin tests_failed++; $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); end
    tests_run++; if (domain_rst !== 2'b11) begin tests_failed++; $display("FAIL reset_domain_rst: got %b expected 11", domain_rst); end
    tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", ready); end
    tests_run++; if (fail !== 1'b0) begin tests_failed++; $display("FAIL reset_fail: got %b expected 0", fail); end
    tests_run++; if (retry_count !== 2'd0) begin tests_failed++; $display("FAIL reset_retry: got %0d expected 0", retry_count); end
    force_relock = 1'b0;
  endtask

  task automatic test_lock_seq();
    do_reset(1'b1);
    goto(3);
    tests_run++; if (pll_rst !== 1'b1) begin tests_failed++; $display("FAIL seq_pll_rst_e3: got %b expected 1", pll_rst); end
    goto(4);
    tests_run++; if (pll_rst !== 1'b0) begin tests_failed++; $display("FAIL seq_pll_rst_e4: got %b expected 0", pll_rst); end
    goto(14);
    tests_run++; if (domain_rst !== 2'b11) begin tests_failed++; $display("FAIL seq_dom_e14: got %b expected 11", domain_rst); end
    goto(15);
    tests_run++; if (domain_rst !== 2'b10) begin tests_failed++; $display("FAIL seq_dom_e15: got %b expected 10", domain_rst); end
    goto(16);
    tests_run++; if (domain_rst !== 2'b10) begin tests_failed++; $display("FAIL seq_dom_e16: got %b expected 10", domain_rst); end
    goto(17);
    tests_run++; if (domain_rst !== 2'b00) begin tests_failed++; $display("FAIL seq_dom_e17: got %b expected 00", domain_rst); end
    tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL seq_ready_e17: got %b expected 0", ready); end
    goto(18);
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL seq_ready_e18: got %b expected 1", ready); end
    tests_run++; if (pll_rst !== 1'b0 || fail !== 1'b0) begin tests_failed++; $display("FAIL seq_run_flags: got pll_rst=%b fail=%b expected 0 0", pll_rst, fail); end
  endtask

  // Continues from test_lock_seq while in RUN.
  task automatic test_lock_loss();
    goto(20);
    pll_locked = 1'b0;
    goto(22);
    tests_run++; if (domain_rst !== 2'b00 || ready !== 1'b1) begin tests_failed++; $display("FAIL loss_hold_e22: got dom=%b ready=%b expected 00 1", domain_rst, ready); end
    goto(23);
    tests_run++; if (domain_rst !== 2'b11) begin tests_failed++; $display("FAIL loss_dom_e23: got %b expected 11", domain_rst); end
    tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL loss_ready_e23: got %b expected 0", ready); end
    tests_run++; if (pll_rst !== 1'b1) begin tests_failed++; $display("FAIL loss_pll_rst_e23: got %b expected 1", pll_rst); end
    tests_run++; if (retry_count !== 2'd0) begin tests_failed++; $display("FAIL loss_retry_e23: got %0d expected 0", retry_count); end
  endtask

  task automatic test_timeout();
    do_reset(1'b0);
    goto(35);
    tests_run++; if (retry_count !== 2'd0 || pll_rst !== 1'b0) begin tests_failed++; $display("FAIL to_e35: got retry=%0d pll_rst=%b expected 0 0", retry_count, pll_rst); end
    goto(36);
    tests_run++; if (retry_count !== 2'd1 || pll_rst !== 1'b1) begin tests_failed++; $display("FAIL to_e36: got retry=%0d pll_rst=%b expected 1 1", retry_count, pll_rst); end
    goto(72);
    tests_run++; if (retry_count !== 2'd2) begin tests_failed++; $display("FAIL to_retry_e72: got %0d expected 2", retry_count); end
    goto(107);
    tests_run++; if (fail !== 1'b0 || pll_rst !== 1'b0) begin tests_failed++; $display("FAIL to_e107: got fail=%b pll_rst=%b expected 0 0", fail, pll_rst); end
    goto(108);
    tests_run++; if (fail !== 1'b1) begin tests_failed++; $display("FAIL to_fail_e108: got %b expected 1", fail); end
    tests_run++; if (pll_rst !== 1'b1 || domain_rst !== 2'b11 || ready !== 1'b0) begin tests_failed++; $display("FAIL to_outs_e108: got pll_rst=%b dom=%b ready=%b expected 1 11 0", pll_rst, domain_rst, ready); end
    goto(140);
    tests_run++; if (fail !== 1'b1 || retry_count !== 2'd2) begin tests_failed++; $display("FAIL to_sticky_e140: got fail=%b retry=%0d expected 1 2", fail, retry_count); end
  endtask

  // Continues from test_timeout in FAIL at edge 140.
  task automatic test_force_from_fail();
    int b;
    pll_locked = 1'b1;
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    b = edges;
    tests_run++; if (fail !== 1'b0 || retry_count !== 2'd0) begin tests_failed++; $display("FAIL ff_clear: got fail=%b retry=%0d expected 0 0", fail, retry_count); end
    tests_run++; if (pll_rst !== 1'b1 || domain_rst !== 2'b11) begin tests_failed++; $display("FAIL ff_outs: got pll_rst=%b dom=%b expected 1 11", pll_rst, domain_rst); end
    goto(b + 3);
    tests_run++; if (pll_rst !== 1'b1) begin tests_failed++; $display("FAIL ff_pll_rst_3: got %b expected 1", pll_rst); end
    goto(b + 4);
    tests_run++; if (pll_rst !== 1'b0) begin tests_failed++; $display("FAIL ff_pll_rst_4: got %b expected 0", pll_rst); end
    goto(b + 15);
    tests_run++; if (domain_rst !== 2'b10) begin tests_failed++; $display("FAIL ff_dom_15: got %b expected 10", domain_rst); end
    goto(b + 17);
    tests_run++; if (domain_rst !== 2'b00 || ready !== 1'b0) begin tests_failed++; $display("FAIL ff_17: got dom=%b ready=%b expected 00 0", domain_rst, ready); end
    goto(b + 18);
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL ff_ready_18: got %b expected 1", ready); end
  endtask

  // force_relock on the final-timeout edge must win over entering FAIL.
  task automatic test_force_timeout();
    do_reset(1'b0);
    goto(107);
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    tests_run++; if (fail !== 1'b0 || retry_count !== 2'd0 || pll_rst !== 1'b1) begin tests_failed++; $display("FAIL ft_e108: got fail=%b retry=%0d pll_rst=%b expected 0 0 1", fail, retry_count, pll_rst); end
    goto(144);
    tests_run++; if (fail !== 1'b0 || retry_count !== 2'd1) begin tests_failed++; $display("FAIL ft_e144: got fail=%b retry=%0d expected 0 1", fail, retry_count); end
  endtask

  task automatic test_glitch_stable();
    do_reset(1'b0);
    goto(36);
    tests_run++; if (retry_count !== 2'd1) begin tests_failed++; $display("FAIL gl_retry_e36: got %0d expected 1", retry_count); end
    pll_locked = 1'b1;
    goto(42);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    goto(51);
    tests_run++; if (domain_rst !== 2'b11) begin tests_failed++; $display("FAIL gl_dom_e51: got %b expected 11", domain_rst); end
    goto(56);
    tests_run++; if (domain_rst !== 2'b10) begin tests_failed++; $display("FAIL gl_dom_e56: got %b expected 10", domain_rst); end
    goto(58);
    tests_run++; if (domain_rst !== 2'b00 || ready !== 1'b0) begin tests_failed++; $display("FAIL gl_e58: got dom=%b ready=%b expected 00 0", domain_rst, ready); end
    goto(59);
    tests_run++; if (ready !== 1'b1 || retry_count !== 2'd1) begin tests_failed++; $display("FAIL gl_e59: got ready=%b retry=%0d expected 1 1", ready, retry_count); end
  endtask

  task automatic test_rst_release();
    do_reset(1'b1);
    goto(15);
    tests_run++; if (domain_rst !== 2'b10) begin tests_failed++; $display("FAIL rr_dom_e15: got %b expected 10", domain_rst); end
    rst = 1'b1;
    tick();
    tests_run++; if (domain_rst !== 2'b11) begin tests_failed++; $display("FAIL rr_dom_abort: got %b expected 11", domain_rst); end
    tests_run++; if (pll_rst !== 1'b1 || ready !== 1'b0) begin tests_failed++; $display("FAIL rr_outs: got pll_rst=%b ready=%b expected 1 0", pll_rst, ready); end
    tick();
    tests_run++; if (domain_rst !== 2'b11) begin tests_failed++; $display("FAIL rr_dom_hold: got %b expected 11", domain_rst); end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pll_locked = 1'b0;
    force_relock = 1'b0;
    @(negedge refclk);
    test_reset();
    test_lock_seq();
    test_lock_loss();
    test_timeout();
    test_force_from_fail();
    test_force_timeout();
    test_glitch_stable();
    test_rst_release();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
